// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one single-port memory.
// Optional fetch starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          halt,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  owner_t owner_r;
  owner_t owner_next_s;
  logic   grant_fetch_s;
  logic   grant_data_s;
  logic   force_fetch_s;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] wait_cnt_r;

  // A fetch that has waited MAX_WAIT cycles pre-empts the data port
  assign force_fetch_s = if_req && !halt && (wait_cnt_r == MAX_WAIT_C);

  // Saturating count of consecutive refused, eligible fetch cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= 4'd0;
    end else if (!if_req || halt || grant_fetch_s) begin
      wait_cnt_r <= 4'd0;
    end else if (wait_cnt_r != 4'hF) begin
      wait_cnt_r <= wait_cnt_r + 4'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end
`else
  logic unused_max_wait_s;

  assign force_fetch_s     = 1'b0;
  assign unused_max_wait_s = ^MAX_WAIT_C;
`endif

  // Single-winner grant: forced fetch, then data, then fetch when not halted
  always_comb begin
    grant_fetch_s = 1'b0;
    grant_data_s  = 1'b0;
    if (force_fetch_s) begin
      grant_fetch_s = 1'b1;
    end else if (d_req) begin
      grant_data_s = 1'b1;
    end else if (if_req && !halt) begin
      grant_fetch_s = 1'b1;
    end else begin
      grant_fetch_s = 1'b0;
      grant_data_s  = 1'b0;
    end
  end

  // Memory command mux; all fields are zero when nothing is granted
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = {DW{1'b0}};
    if (grant_data_s) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (grant_fetch_s) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end else begin
      mem_en = 1'b0;
    end
  end

  assign if_ack = grant_fetch_s;
  assign d_ack  = grant_data_s;

  // Owner of the read whose data returns next cycle; writes own nothing
  always_comb begin
    owner_next_s = OWN_NONE;
    if (grant_fetch_s) begin
      owner_next_s = OWN_FETCH;
    end else if (grant_data_s && !d_we) begin
      owner_next_s = OWN_DATA;
    end else begin
      owner_next_s = OWN_NONE;
    end
  end

  // Owner register; reset discards any read granted during reset
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_r <= OWN_NONE;
    end else begin
      owner_r <= owner_next_s;
    end
  end

  // Route the read-valid strobe to the recorded owner
  always_comb begin
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    case (owner_r)
      OWN_FETCH: if_rvalid = 1'b1;
      OWN_DATA:  d_rvalid  = 1'b1;
      OWN_NONE:  if_rvalid = 1'b0;
      default: begin
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
      end
    endcase
  end

  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule
